// File: rtl/keccak_squeeze_stream_pkg.sv
// Keccak shared package: state geometry, mode encodings and squeeze helpers.
// Provides the per-mode rate and digest lengths, the beat byte-count helper,
// and the squeeze FSM state type used by keccak_squeeze_stream.
package keccak_pkg;

  localparam int unsigned ROW_SIZE       = 5;
  localparam int unsigned COL_SIZE       = 5;
  localparam int unsigned LANE_SIZE      = 64;
  localparam int unsigned STATE_WIDTH    = ROW_SIZE * COL_SIZE * LANE_SIZE;
  localparam int unsigned MODE_SEL_WIDTH = 2;

  localparam logic [MODE_SEL_WIDTH-1:0] SHA3_256 = 2'd0;
  localparam logic [MODE_SEL_WIDTH-1:0] SHA3_512 = 2'd1;
  localparam logic [MODE_SEL_WIDTH-1:0] SHAKE128 = 2'd2;
  localparam logic [MODE_SEL_WIDTH-1:0] SHAKE256 = 2'd3;

  typedef enum logic [1:0] {
    SQZ_IDLE,
    SQZ_FILL,
    SQZ_OUT,
    SQZ_PERM
  } squeeze_state_e;

  function automatic int unsigned out_bytes(input int unsigned dwidth);
    return dwidth / 8;
  endfunction

  function automatic logic [7:0] rate_bytes(input logic [MODE_SEL_WIDTH-1:0] mode);
    case (mode)
      SHA3_256: return 8'd136;
      SHA3_512: return 8'd72;
      SHAKE128: return 8'd168;
      default:  return 8'd136;
    endcase
  endfunction

  function automatic logic is_xof(input logic [MODE_SEL_WIDTH-1:0] mode);
    return (mode == SHAKE128) || (mode == SHAKE256);
  endfunction

  // Fixed digest length; XOF modes take their length from the caller.
  function automatic logic [7:0] digest_bytes(input logic [MODE_SEL_WIDTH-1:0] mode);
    case (mode)
      SHA3_256: return 8'd32;
      SHA3_512: return 8'd64;
      default:  return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/keccak_squeeze_stream_extract.sv
// keccak_state_byte_extract: combinational byte window over the Keccak state.
// Byte k of the state is bits [8k+7:8k] (lane x+5*y, little-endian in lane).
// Ports:
//   state  - flat 1600-bit state
//   offset - first byte to extract
//   count  - number of bytes kept; bytes at or beyond count are zeroed
//   window - OUT_DWIDTH-bit result, extracted byte 0 in bits [7:0]
module keccak_state_byte_extract
  import keccak_pkg::*;
#(
  parameter int unsigned OUT_DWIDTH = 256,
  localparam int unsigned OUT_BYTES = OUT_DWIDTH / 8,
  localparam int unsigned CNT_W     = $clog2(OUT_BYTES) + 1
) (
  input  logic [STATE_WIDTH-1:0] state,
  input  logic [7:0]             offset,
  input  logic [CNT_W-1:0]       count,
  output logic [OUT_DWIDTH-1:0]  window
);

  always_comb begin
    window = OUT_DWIDTH'(state >> {offset, 3'b000});
    for (int unsigned i = 0; i < OUT_BYTES; i++) begin
      if (i >= 32'(count)) window[i*8 +: 8] = '0;
    end
  end

endmodule

// File: rtl/keccak_squeeze_stream.sv
// keccak_squeeze_stream: drains the sponge rate as a packed byte stream.
// Requests permutations at rate boundaries and carries partial beats across
// them so only the final beat may be short.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start_i             - begin squeeze (IDLE only); mode/out_len sampled here
//   keccak_mode_i       - SHA3_256/SHA3_512/SHAKE128/SHAKE256
//   out_len_i           - XOF length in bytes
//   state_array_i       - current Keccak state
//   perm_req_o/perm_done_i - permutation request level / completion pulse
//   t_data_o/t_keep_o/t_valid_o/t_ready_i/t_last_o - output stream
//   busy_o, done_o      - not idle / completion pulse
module keccak_squeeze_stream
  import keccak_pkg::*;
#(
  parameter int unsigned OUT_DWIDTH    = 256,
  parameter int unsigned OUT_LEN_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start_i,
  input  logic [MODE_SEL_WIDTH-1:0]              keccak_mode_i,
  input  logic [OUT_LEN_WIDTH-1:0]               out_len_i,
  input  logic [ROW_SIZE*COL_SIZE*LANE_SIZE-1:0] state_array_i,
  output logic                                   perm_req_o,
  input  logic                                   perm_done_i,
  output logic [OUT_DWIDTH-1:0]                  t_data_o,
  output logic [OUT_DWIDTH/8-1:0]                t_keep_o,
  output logic                                   t_valid_o,
  input  logic                                   t_ready_i,
  output logic                                   t_last_o,
  output logic                                   busy_o,
  output logic                                   done_o
);

  localparam int unsigned OUT_BYTES = out_bytes(OUT_DWIDTH);
  localparam int unsigned CNT_W     = $clog2(OUT_BYTES) + 1;

  squeeze_state_e state_q, state_d;

  logic [7:0]               rate_q;
  logic [7:0]               rate_off_q;
  logic [OUT_LEN_WIDTH-1:0] remaining_q;
  logic [CNT_W-1:0]         carry_q;
  logic [CNT_W-1:0]         beat_len_q;
  logic [OUT_DWIDTH-1:0]    buf_q;
  logic [OUT_DWIDTH-1:0]    data_q;
  logic [OUT_BYTES-1:0]     keep_q;
  logic                     valid_q;
  logic                     last_q;
  logic                     done_q;

  logic [OUT_LEN_WIDTH-1:0] start_len;
  logic [31:0]              beat_room, rate_room, len_room, take_min;
  logic [CNT_W-1:0]         take;
  logic [CNT_W-1:0]         filled;
  logic [OUT_DWIDTH-1:0]    window;
  logic [OUT_DWIDTH-1:0]    merged;
  logic [OUT_BYTES-1:0]     keep_mask;
  logic                     beat_full;
  logic                     beat_final;

  keccak_state_byte_extract #(
    .OUT_DWIDTH(OUT_DWIDTH)
  ) u_extract (
    .state  (state_array_i),
    .offset (rate_off_q),
    .count  (take),
    .window (window)
  );

  // Bytes moved this FILL: bounded by beat space, rate left, and length left.
  always_comb begin
    start_len  = is_xof(keccak_mode_i) ? out_len_i
                                       : OUT_LEN_WIDTH'(digest_bytes(keccak_mode_i));
    beat_room  = OUT_BYTES - 32'(carry_q);
    rate_room  = 32'(rate_q) - 32'(rate_off_q);
    len_room   = 32'(remaining_q) - 32'(carry_q);
    take_min   = beat_room;
    if (rate_room < take_min) take_min = rate_room;
    if (len_room < take_min)  take_min = len_room;
    take       = CNT_W'(take_min);
    filled     = carry_q + take;
    // New bytes land just above those carried over from the previous rate block.
    merged     = buf_q | (window << {carry_q, 3'b000});
    beat_full  = (32'(filled) == OUT_BYTES);
    beat_final = (32'(filled) == 32'(remaining_q));
    for (int unsigned i = 0; i < OUT_BYTES; i++) begin
      keep_mask[i] = (i < 32'(filled));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SQZ_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    perm_req_o = 1'b0;
    busy_o     = (state_q != SQZ_IDLE);
    case (state_q)
      SQZ_IDLE: begin
        if (start_i && (start_len != '0)) state_d = SQZ_FILL;
      end
      SQZ_FILL: begin
        state_d = (beat_full || beat_final) ? SQZ_OUT : SQZ_PERM;
      end
      SQZ_OUT: begin
        // Last beat wins over the rate boundary: never permute after the end.
        if (t_ready_i) begin
          if (last_q)                       state_d = SQZ_IDLE;
          else if (rate_off_q == rate_q)    state_d = SQZ_PERM;
          else                              state_d = SQZ_FILL;
        end
      end
      SQZ_PERM: begin
        perm_req_o = 1'b1;
        if (perm_done_i) state_d = SQZ_FILL;
      end
      default: state_d = SQZ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rate_q      <= '0;
      rate_off_q  <= '0;
      remaining_q <= '0;
      carry_q     <= '0;
      beat_len_q  <= '0;
      buf_q       <= '0;
      data_q      <= '0;
      keep_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SQZ_IDLE: begin
          if (start_i) begin
            rate_q      <= rate_bytes(keccak_mode_i);
            remaining_q <= start_len;
            rate_off_q  <= '0;
            carry_q     <= '0;
            buf_q       <= '0;
            if (start_len == '0) done_q <= 1'b1;
          end
        end
        SQZ_FILL: begin
          rate_off_q <= rate_off_q + 8'(take);
          if (beat_full || beat_final) begin
            data_q     <= merged;
            keep_q     <= keep_mask;
            last_q     <= beat_final;
            valid_q    <= 1'b1;
            beat_len_q <= filled;
            buf_q      <= '0;
            carry_q    <= '0;
          end else begin
            carry_q <= filled;
            buf_q   <= merged;
          end
        end
        SQZ_OUT: begin
          if (t_ready_i) begin
            valid_q     <= 1'b0;
            remaining_q <= remaining_q - OUT_LEN_WIDTH'(beat_len_q);
            if (last_q) done_q <= 1'b1;
          end
        end
        SQZ_PERM: begin
          if (perm_done_i) rate_off_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign t_data_o  = data_q;
  assign t_keep_o  = keep_q;
  assign t_valid_o = valid_q;
  assign t_last_o  = last_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_keccak_squeeze_stream.sv
// Directed bench for keccak_squeeze_stream: one 256-bit and one 64-bit instance.
module tb_keccak_squeeze_stream;
  import keccak_pkg::*;

  logic clk;
  logic rst;
  logic start_a, start_b;
  logic [1:0] mode;
  logic [15:0] out_len;
  logic [1599:0] state_arr;
  logic perm_done;
  logic ready;

  logic perm_req_a, t_valid_a, t_last_a, busy_a, done_a;
  logic [255:0] t_data_a;
  logic [31:0] t_keep_a;
  logic perm_req_b, t_valid_b, t_last_b, busy_b, done_b;
  logic [63:0] t_data_b;
  logic [7:0] t_keep_b;

  int checks = 0;
  int errors = 0;
  int gen = 0;
  bit svc = 1;
  int perm_rise_a = 0, perm_rise_b = 0;
  logic pa_prev = 1'b0, pb_prev = 1'b0;

  keccak_squeeze_stream #(.OUT_DWIDTH(256), .OUT_LEN_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .keccak_mode_i(mode), .out_len_i(out_len),
    .state_array_i(state_arr), .perm_req_o(perm_req_a), .perm_done_i(perm_done),
    .t_data_o(t_data_a), .t_keep_o(t_keep_a), .t_valid_o(t_valid_a), .t_ready_i(ready),
    .t_last_o(t_last_a), .busy_o(busy_a), .done_o(done_a)
  );

  keccak_squeeze_stream #(.OUT_DWIDTH(64), .OUT_LEN_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .keccak_mode_i(mode), .out_len_i(out_len),
    .state_array_i(state_arr), .perm_req_o(perm_req_b), .perm_done_i(perm_done),
    .t_data_o(t_data_b), .t_keep_o(t_keep_b), .t_valid_o(t_valid_b), .t_ready_i(ready),
    .t_last_o(t_last_b), .busy_o(busy_b), .done_o(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // State byte k after g permutations.
  function automatic logic [7:0] pat(input int k, input int g);
    return 8'((k * 7 + g * 101 + 3) % 256);
  endfunction

  always_comb begin
    for (int k = 0; k < 200; k++) state_arr[k*8 +: 8] = pat(k, gen);
  end

  always @(negedge clk) begin
    if (perm_req_a && !pa_prev) perm_rise_a++;
    if (perm_req_b && !pb_prev) perm_rise_b++;
    pa_prev = perm_req_a;
    pb_prev = perm_req_b;
  end

  // Stream byte j of a squeeze sits in block j/rate at rate offset j%rate.
  function automatic logic [255:0] exp_data(input int s, input int nb, input int rate);
    logic [255:0] d;
    d = '0;
    for (int i = 0; i < nb; i++) d[i*8 +: 8] = pat((s + i) % rate, (s + i) / rate);
    return d;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input bit sel, input string tag, input int s, input int nb,
                            input int rate, input bit last);
    logic [63:0] keep_exp;
    keep_exp = (64'd1 << nb) - 64'd1;
    if (sel) begin
      check({tag, "_data"}, {192'd0, t_data_b}, exp_data(s, nb, rate));
      check({tag, "_keep"}, {248'd0, t_keep_b}, {192'd0, keep_exp});
      check({tag, "_last"}, {255'd0, t_last_b}, {255'd0, last});
    end else begin
      check({tag, "_data"}, t_data_a, exp_data(s, nb, rate));
      check({tag, "_keep"}, {224'd0, t_keep_a}, {192'd0, keep_exp});
      check({tag, "_last"}, {255'd0, t_last_a}, {255'd0, last});
    end
  endtask

  // Waits (bounded) for t_valid, answering permutation requests when svc is set.
  task automatic wait_beat(input bit sel);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (perm_done) perm_done = 1'b0;
      else if (svc && (sel ? perm_req_b : perm_req_a)) begin
        gen = gen + 1;
        perm_done = 1'b1;
      end
      if (sel ? t_valid_b : t_valid_a) ok = 1'b1;
    end
    check("beat_timeout", {255'd0, ok}, 256'd1);
  endtask

  task automatic do_start(input bit sel, input logic [1:0] m, input logic [15:0] len);
    @(negedge clk);
    mode = m;
    out_len = len;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic check_done(input bit sel, input string tag);
    @(negedge clk);
    check({tag, "_done"}, {255'd0, sel ? done_b : done_a}, 256'd1);
    check({tag, "_busy"}, {255'd0, sel ? busy_b : busy_a}, 256'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {255'd0, sel ? done_b : done_a}, 256'd0);
  endtask

  initial begin
    int pr, s, nb;
    bit ok;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = '0; out_len = '0;
    perm_done = 1'b0; ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", {255'd0, t_valid_a}, 256'd0);
    check("rst_keep", {224'd0, t_keep_a}, 256'd0);
    check("rst_data", t_data_a, 256'd0);
    check("rst_last", {255'd0, t_last_a}, 256'd0);
    check("rst_perm", {255'd0, perm_req_a}, 256'd0);
    check("rst_busy", {255'd0, busy_a}, 256'd0);
    check("rst_done", {255'd0, done_a}, 256'd0);
    rst = 1'b0;

    // SHA3-256: single full last beat, no permutation.
    gen = 0; pr = perm_rise_a;
    do_start(0, SHA3_256, 16'd0);
    wait_beat(0);
    check_beat(0, "sha256", 0, 32, 136, 1'b1);
    check_done(0, "sha256");
    check("sha256_noperm", 256'(perm_rise_a - pr), 256'd0);

    // SHAKE128, 200 bytes: one permutation, beat 6 spans it, beat 7 short.
    gen = 0; pr = perm_rise_a;
    do_start(0, SHAKE128, 16'd200);
    for (int b = 0; b < 7; b++) begin
      s = 32 * b;
      nb = (200 - s < 32) ? 200 - s : 32;
      wait_beat(0);
      check_beat(0, $sformatf("shake128_b%0d", b), s, nb, 168, (s + nb) == 200);
    end
    check_done(0, "shake128");
    check("shake128_perms", 256'(perm_rise_a - pr), 256'd1);

    // Backpressure: SHAKE256 96 bytes, first beat held for 5 cycles.
    gen = 0; ready = 1'b0;
    do_start(0, SHAKE256, 16'd96);
    wait_beat(0);
    check_beat(0, "bp_b0", 0, 32, 136, 1'b0);
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      check_beat(0, $sformatf("bp_hold%0d", h), 0, 32, 136, 1'b0);
      check("bp_valid_held", {255'd0, t_valid_a}, 256'd1);
    end
    ready = 1'b1;
    for (int b = 1; b < 3; b++) begin
      wait_beat(0);
      check_beat(0, $sformatf("bp_b%0d", b), 32 * b, 32, 136, b == 2);
    end
    check_done(0, "bp");

    // Zero-length XOF.
    do_start(0, SHAKE128, 16'd0);
    check("len0_done", {255'd0, done_a}, 256'd1);
    check("len0_valid", {255'd0, t_valid_a}, 256'd0);
    @(negedge clk);
    check("len0_done_pulse", {255'd0, done_a}, 256'd0);
    check("len0_valid2", {255'd0, t_valid_a}, 256'd0);

    // 64-bit bus: SHAKE256 136 bytes ends on the rate boundary with no permutation.
    gen = 0; pr = perm_rise_b;
    do_start(1, SHAKE256, 16'd136);
    for (int b = 0; b < 17; b++) begin
      wait_beat(1);
      check_beat(1, $sformatf("w64_b%0d", b), 8 * b, 8, 136, b == 16);
    end
    check_done(1, "w64");
    check("w64_noperm", 256'(perm_rise_b - pr), 256'd0);

    // Reset while waiting in PERM, then a late perm_done.
    gen = 0; svc = 1'b0;
    do_start(0, SHAKE128, 16'd200);
    for (int b = 0; b < 5; b++) begin
      wait_beat(0);
      check_beat(0, $sformatf("rp_b%0d", b), 32 * b, 32, 168, 1'b0);
    end
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (perm_req_a) ok = 1'b1;
    end
    check("rp_perm_req", {255'd0, ok}, 256'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; perm_done = 1'b1;
    @(negedge clk);
    perm_done = 1'b0;
    check("rp_valid", {255'd0, t_valid_a}, 256'd0);
    check("rp_perm", {255'd0, perm_req_a}, 256'd0);
    check("rp_busy", {255'd0, busy_a}, 256'd0);
    check("rp_keep", {224'd0, t_keep_a}, 256'd0);
    check("rp_data", t_data_a, 256'd0);
    check("rp_done", {255'd0, done_a}, 256'd0);
    @(negedge clk);
    check("rp_idle", {255'd0, busy_a | t_valid_a | perm_req_a}, 256'd0);
    svc = 1'b1; gen = 0; pr = perm_rise_a;
    do_start(0, SHA3_512, 16'd0);
    for (int b = 0; b < 2; b++) begin
      wait_beat(0);
      check_beat(0, $sformatf("sha512_b%0d", b), 32 * b, 32, 72, b == 1);
    end
    check_done(0, "sha512");
    check("sha512_noperm", 256'(perm_rise_a - pr), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keccak_squeeze_stream.md
Name: keccak_squeeze_stream

Overview:
- Sequential, parametrised squeeze engine for the Keccak sponge.
- Drains the rate portion of the state as a packed, AXI-stream-style byte stream of OUT_DWIDTH bits per beat.
- Requests permutations itself at rate boundaries and carries partial beats across them, so every beat except the last is full.
- Supports SHA3-256/512 fixed digests and SHAKE128/256 with a caller-specified output length; sits between the permutation core/FSM and the host output port.

Parameters:
- OUT_DWIDTH, 256, output bus width in bits; multiple of 64, range 64..512.
- OUT_LEN_WIDTH, 16, width of requested XOF output length in bytes.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse; begin squeeze (accepted only in IDLE).
- keccak_mode_i  in  MODE_SEL_WIDTH  mode, sampled on start_i.
- out_len_i  in  OUT_LEN_WIDTH  XOF length in bytes, sampled on start_i; ignored for SHA3.
- state_array_i  in  ROW_SIZE*COL_SIZE*LANE_SIZE  current state; stable whenever perm_req_o=0 and busy_o=1.
- perm_req_o  out  1  level; permutation wanted.
- perm_done_i  in  1  one-cycle pulse; state updated.
- t_data_o  out  OUT_DWIDTH  beat data, byte 0 in bits [7:0].
- t_keep_o  out  OUT_DWIDTH/8  valid bytes, contiguous from bit 0.
- t_valid_o  out  1  beat valid.
- t_ready_i  in  1  sink ready.
- t_last_o  out  1  final beat of digest.
- busy_o  out  1  not IDLE.
- done_o  out  1  one-cycle pulse when squeeze completes.

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters 0. Reset in any state, including mid-PERM or with t_valid_o high, aborts with no further beats. A pending perm_done_i is ignored.
- Rate bytes per mode (package): SHA3_256 136, SHA3_512 72, SHAKE128 168, SHAKE256 136.
- Length: SHA3_256 32, SHA3_512 64, SHAKE out_len_i.
- Linear byte order: lane index x+5*y, little-endian within lane.
- Registers: rate_off (0..rate), remaining (bytes not yet emitted), carry_cnt (bytes already packed in beat buffer, < OUT_DWIDTH/8), beat buffer.
- IDLE: on start_i, latch mode/rate/len, rate_off=0, carry_cnt=0, busy_o=1.
  - len=0: done_o pulses next cycle, stay IDLE, no beats.
  - Otherwise go FILL. start_i outside IDLE is ignored.
- FILL (1 cycle):
  - n = min(OUT_BYTES-carry_cnt, rate-rate_off, remaining-carry_cnt).
  - Copy state bytes [rate_off +: n] to buffer bytes [carry_cnt +: n]; rate_off+=n.
  - If carry_cnt+n == OUT_BYTES or == remaining: load outputs, t_keep_o = low (carry_cnt+n) bits set, t_last_o = (carry_cnt+n == remaining); go OUT.
  - Else (rate exhausted): carry_cnt+=n, go PERM.
- OUT: t_valid_o=1; data/keep/last held stable until t_ready_i.
  - On handshake: remaining-=beat bytes, carry_cnt=0, t_valid_o=0 next cycle.
  - If last: done_o pulse, go IDLE.
  - Else if rate_off==rate: go PERM.
  - Else: go FILL.
- PERM: perm_req_o=1 until the cycle perm_done_i is seen; then rate_off=0, go FILL. perm_done_i outside PERM is ignored.
- No permutation is ever requested after the final byte, even when the final byte ends exactly on a rate boundary.
- Throughput: one beat per 2 cycles with t_ready_i held high.

Decomposition:
- keccak_pkg additions: OUT_BYTES helper function, rate-bytes-per-mode function, digest-length-per-mode function, squeeze FSM state enum.
- Existing package constants reused: MODE_SEL_WIDTH, ROW/COL/LANE_SIZE, mode encodings.
- One sub-module: keccak_state_byte_extract. Combinational; given state, byte offset and count, returns an OUT_DWIDTH window with bytes beyond count zeroed.

Test Plan:
- SHA3_256, OUT_DWIDTH=256, ready=1 -> one beat, t_keep_o=all 1s, t_last_o=1, data=state bytes 0..31, perm_req_o never asserted, done_o pulse.
- SHAKE128, len=200, OUT_DWIDTH=256 -> beats 1-5 full.
  - Then perm_req_o once; beat 6 = old bytes 160..167 + new bytes 0..23.
  - Beat 7 keep=0xFF, last=1, data = new bytes 24..31.
- SHAKE256, len=136, OUT_DWIDTH=64 -> 17 full beats, last on 17th, perm_req_o never asserted.
- Backpressure: t_ready_i low 5 cycles mid-stream -> t_data_o/t_keep_o/t_last_o unchanged, no bytes lost or duplicated.
- SHAKE128, len=0 -> done_o one cycle after start_i, t_valid_o stays 0.
- Reset asserted in PERM with perm_done_i arriving the next cycle -> all outputs 0, IDLE; a new SHA3_512 start gives 2 beats, second last.
